// File: rtl/counter_pair_sampler.sv
`default_nettype none
// ============================================================================
// Module   : counter_pair_sampler
// Brief    : Periodic sampler of a counter pair; tagged snapshots into a FWFT FIFO
// Revision : 1.0 - initial release
// ============================================================================
module counter_pair_sampler #(
    parameter int WIDTH      = 4,
    parameter int DEPTH      = 4,
    parameter int SAMPLE_DIV = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         counter1,
    input  logic [WIDTH-1:0]         counter2,
    input  logic                     sample_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_c1,
    output logic [WIDTH-1:0]         out_c2,
    output logic [WIDTH-1:0]         out_diff,
    output logic                     out_mismatch,
    output logic [7:0]               out_tag,
    output logic [7:0]               drop_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int c_AW   = $clog2(DEPTH);
    localparam int c_LW   = c_AW + 1;
    localparam int c_DIVW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [c_DIVW-1:0] c_DIV_LAST = c_DIVW'(SAMPLE_DIV - 1);
    localparam logic [c_LW-1:0]   c_FULL     = c_LW'(DEPTH);

    logic [c_DIVW-1:0] r_div;
    logic [7:0]        r_seq;
    logic [7:0]        r_drop;
    logic [c_LW-1:0]   r_level;
    logic [c_AW-1:0]   r_wr;
    logic [c_AW-1:0]   r_rd;

    logic [WIDTH-1:0]  r_mem_c1   [DEPTH];
    logic [WIDTH-1:0]  r_mem_c2   [DEPTH];
    logic [WIDTH-1:0]  r_mem_diff [DEPTH];
    logic              r_mem_mm   [DEPTH];
    logic [7:0]        r_mem_tag  [DEPTH];

    logic w_strobe;
    logic w_full;
    logic w_valid;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_valid  = (r_level != '0);
    assign w_full   = (r_level == c_FULL);
    assign w_strobe = sample_en && (r_div == c_DIV_LAST);
    assign w_pop    = w_valid && out_ready;
    // A full FIFO still accepts the snapshot when the head leaves on the same edge.
    assign w_push   = w_strobe && (!w_full || w_pop);
    assign w_drop   = w_strobe && w_full && !w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div   <= '0;
            r_seq   <= '0;
            r_drop  <= '0;
            r_level <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
        end else begin
            if (sample_en) begin
                r_div <= w_strobe ? '0 : r_div + 1'b1;
            end
            if (w_strobe) begin
                r_seq <= r_seq + 8'd1;
            end
            if (w_drop && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: every field is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_c1[r_wr]   <= counter1;
            r_mem_c2[r_wr]   <= counter2;
            r_mem_diff[r_wr] <= counter1 - counter2;
            r_mem_mm[r_wr]   <= (counter1 != counter2);
            r_mem_tag[r_wr]  <= r_seq;
        end
    end

    assign out_valid    = w_valid;
    assign out_c1       = w_valid ? r_mem_c1[r_rd]   : '0;
    assign out_c2       = w_valid ? r_mem_c2[r_rd]   : '0;
    assign out_diff     = w_valid ? r_mem_diff[r_rd] : '0;
    assign out_mismatch = w_valid ? r_mem_mm[r_rd]   : 1'b0;
    assign out_tag      = w_valid ? r_mem_tag[r_rd]  : 8'd0;
    assign drop_count   = r_drop;
    assign fifo_level   = r_level;

endmodule
`default_nettype wire

// File: tb/tb_counter_pair_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_pair_sampler
// Brief    : Self-checking bench: vector table, corner sequences, random vs model
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_pair_sampler;

    localparam int WIDTH      = 4;
    localparam int DEPTH      = 4;
    localparam int SAMPLE_DIV = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] counter1 = '0;
    logic [WIDTH-1:0] counter2 = '0;
    logic             sample_en = 1'b0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [WIDTH-1:0] out_c1, out_c2, out_diff;
    logic             out_mismatch;
    logic [7:0]       out_tag, drop_count;
    logic [2:0]       fifo_level;

    int checks   = 0;
    int failures = 0;

    counter_pair_sampler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SAMPLE_DIV(SAMPLE_DIV)) dut (
        .clk(clk), .rst(rst), .counter1(counter1), .counter2(counter2),
        .sample_en(sample_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_c1(out_c1), .out_c2(out_c2), .out_diff(out_diff),
        .out_mismatch(out_mismatch), .out_tag(out_tag),
        .drop_count(drop_count), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of snapshots plus plain integer counters.
    typedef struct {
        int c1;
        int c2;
        int tag;
    } snap_t;
    snap_t m_q[$];
    int    m_div;
    int    m_seq;
    int    m_drop;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_div  = 0;
        m_seq  = 0;
        m_drop = 0;
    endtask

    task automatic model_step(input bit en, input bit rdy, input int a, input int b);
        bit pop;
        bit strobe;
        snap_t s;
        pop    = (m_q.size() != 0) && rdy;
        strobe = en && (m_div == SAMPLE_DIV - 1);
        if (en) m_div = strobe ? 0 : m_div + 1;
        if (pop) void'(m_q.pop_front());
        if (strobe) begin
            if (m_q.size() < DEPTH) begin
                s.c1 = a; s.c2 = b; s.tag = m_seq;
                m_q.push_back(s);
            end else if (m_drop < 255) begin
                m_drop++;
            end
            m_seq = (m_seq + 1) % 256;
        end
    endtask

    task automatic compare_model();
        int e_c1, e_c2, e_tag;
        e_c1 = 0; e_c2 = 0; e_tag = 0;
        if (m_q.size() != 0) begin
            e_c1 = m_q[0].c1; e_c2 = m_q[0].c2; e_tag = m_q[0].tag;
        end
        chk("model_valid", int'(out_valid), int'(m_q.size() != 0));
        chk("model_level", int'(fifo_level), m_q.size());
        chk("model_drop", int'(drop_count), m_drop);
        chk("model_c1", int'(out_c1), e_c1);
        chk("model_c2", int'(out_c2), e_c2);
        chk("model_diff", int'(out_diff), (m_q.size() != 0) ? ((e_c1 - e_c2) & 15) : 0);
        chk("model_mismatch", int'(out_mismatch), int'((m_q.size() != 0) && (e_c1 != e_c2)));
        chk("model_tag", int'(out_tag), e_tag);
    endtask

    task automatic tick(input bit en, input bit rdy, input logic [3:0] a, input logic [3:0] b);
        sample_en = en; out_ready = rdy; counter1 = a; counter2 = b;
        @(posedge clk);
        model_step(en, rdy, int'(a), int'(b));
        #1;
        compare_model();
    endtask

    // Reset asserted between edges; outputs must clear before any clock edge.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_drop", int'(drop_count), 0);
        chk("rst_tag", int'(out_tag), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0] c1;
        logic [3:0] c2;
        logic [3:0] diff;
        logic       mm;
    } vec_t;
    vec_t vt[6];

    initial begin
        vt[0] = '{4'd3,  4'd3, 4'd0,  1'b0};
        vt[1] = '{4'd2,  4'd5, 4'd13, 1'b1};
        vt[2] = '{4'd15, 4'd0, 4'd15, 1'b1};
        vt[3] = '{4'd0,  4'd1, 4'd15, 1'b1};
        vt[4] = '{4'd9,  4'd9, 4'd0,  1'b0};
        vt[5] = '{4'd7,  4'd2, 4'd5,  1'b1};

        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Table: first snapshot after reset, held at the head.
        for (int i = 0; i < 6; i++) begin
            async_reset();
            for (int k = 0; k < 7; k++) tick(1'b1, 1'b0, vt[i].c1, vt[i].c2);
            chk("tbl_not_yet", int'(out_valid), 0);
            tick(1'b1, 1'b0, vt[i].c1, vt[i].c2);
            chk("tbl_valid", int'(out_valid), 1);
            chk("tbl_c1", int'(out_c1), int'(vt[i].c1));
            chk("tbl_c2", int'(out_c2), int'(vt[i].c2));
            chk("tbl_diff", int'(out_diff), int'(vt[i].diff));
            chk("tbl_mm", int'(out_mismatch), int'(vt[i].mm));
            chk("tbl_tag", int'(out_tag), 0);
        end

        // Plan 1: consumer ready, snapshots every 8 cycles.
        async_reset();
        for (int k = 0; k < 8; k++) tick(1'b1, 1'b1, 4'd3, 4'd3);
        chk("p1_tag0", int'(out_tag), 0);
        tick(1'b1, 1'b1, 4'd3, 4'd3);
        chk("p1_popped", int'(out_valid), 0);
        for (int k = 0; k < 7; k++) tick(1'b1, 1'b1, 4'd3, 4'd3);
        chk("p1_tag1_valid", int'(out_valid), 1);
        chk("p1_tag1", int'(out_tag), 1);

        // Plan 3: six strobes with no consumer, then drain.
        async_reset();
        for (int k = 0; k < 48; k++) tick(1'b1, 1'b0, 4'(k), 4'(k + 1));
        chk("p3_level", int'(fifo_level), 4);
        chk("p3_drop", int'(drop_count), 2);
        for (int t = 0; t < 4; t++) begin
            chk("p3_drain_tag", int'(out_tag), t);
            tick(1'b0, 1'b1, 4'd0, 4'd0);
        end
        chk("p3_empty", int'(out_valid), 0);
        for (int k = 0; k < 8; k++) tick(1'b1, 1'b0, 4'd1, 4'd1);
        chk("p3_next_tag", int'(out_tag), 6);

        // Plan 4: full FIFO, pop and push on the same strobe edge.
        async_reset();
        for (int k = 0; k < 32; k++) tick(1'b1, 1'b0, 4'd4, 4'd4);
        chk("p4_full", int'(fifo_level), 4);
        for (int k = 0; k < 7; k++) tick(1'b1, 1'b0, 4'd4, 4'd4);
        tick(1'b1, 1'b1, 4'd4, 4'd4);
        chk("p4_level", int'(fifo_level), 4);
        chk("p4_drop", int'(drop_count), 0);
        chk("p4_head", int'(out_tag), 1);

        // Plan 5: divider holds while disabled.
        async_reset();
        for (int k = 0; k < 5; k++) tick(1'b1, 1'b0, 4'd5, 4'd5);
        for (int k = 0; k < 10; k++) tick(1'b0, 1'b0, 4'd5, 4'd5);
        tick(1'b1, 1'b0, 4'd5, 4'd5);
        tick(1'b1, 1'b0, 4'd5, 4'd5);
        chk("p5_before", int'(out_valid), 0);
        tick(1'b1, 1'b0, 4'd5, 4'd5);
        chk("p5_strobe", int'(out_valid), 1);

        // Plan 6: reset mid-operation with level=3, drop=7.
        async_reset();
        for (int k = 0; k < 88; k++) tick(1'b1, 1'b0, 4'd6, 4'd2);
        chk("p6_drop7", int'(drop_count), 7);
        tick(1'b0, 1'b1, 4'd6, 4'd2);
        chk("p6_level3", int'(fifo_level), 3);
        async_reset();
        for (int k = 0; k < 7; k++) tick(1'b1, 1'b0, 4'd6, 4'd2);
        chk("p6_not_yet", int'(out_valid), 0);
        tick(1'b1, 1'b0, 4'd6, 4'd2);
        chk("p6_tag0", int'(out_tag), 0);
        chk("p6_valid", int'(out_valid), 1);

        // Randomized traffic against the model, with occasional resets.
        async_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 499) == 0) async_reset();
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 4'($urandom), 4'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
